// File: rtl/cp0_regfile_if.sv
// Execute/commit-side bus into the CP0 register file: mtc0/mfc0 access,
// exception/eret events, and the architectural state and interrupt request going back.
interface cp0_regfile_if;
  logic        cp0_w_ena;
  logic [4:0]  cp0_w_addr;
  logic [31:0] cp0_w_data;
  logic [4:0]  cp0_r_addr;
  logic [31:0] cp0_r_data;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic        int_req;

  modport master (
    output cp0_w_ena, cp0_w_addr, cp0_w_data, cp0_r_addr, hw_int,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    input  cp0_r_data, cp0_epc, cp0_status, cp0_cause, int_req
  );

  modport slave (
    input  cp0_w_ena, cp0_w_addr, cp0_w_data, cp0_r_addr, hw_int,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
    output cp0_r_data, cp0_epc, cp0_status, cp0_cause, int_req
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr/Count/Compare/Status/Cause/EPC, Count/Compare
// timer and merged hardware/timer interrupt request.
module cp0_regfile (
  input  logic          clk,
  input  logic          rst,
  cp0_regfile_if.slave  bus
);
  localparam logic [4:0] A_BADV = 5'd8,  A_COUNT = 5'd9,  A_COMP = 5'd11,
                         A_STAT = 5'd12, A_CAUSE = 5'd13, A_EPC  = 5'd14;

  logic [31:0] badv_q, badv_d, count_q, count_d, comp_q, comp_d, epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d, tick_q, tick_d;
  logic [5:0]  iphw_q, iphw_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [4:0]  exc_q, exc_d;
  logic [7:0]  ip;
  logic [31:0] status, cause;

  // IP7 is shared between external line 5 and the timer
  assign ip     = {iphw_q[5] | ti_q, iphw_q[4:0], ipsw_q};
  assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_q, 2'b0};

  assign bus.cp0_status = status;
  assign bus.cp0_cause  = cause;
  assign bus.cp0_epc    = epc_q;
  assign bus.int_req    = ie_q & ~exl_q & |(ip & im_q);

  always_comb begin
    bus.cp0_r_data = 32'h0;
    case (bus.cp0_r_addr)
      A_BADV:  bus.cp0_r_data = badv_q;
      A_COUNT: bus.cp0_r_data = count_q;
      A_COMP:  bus.cp0_r_data = comp_q;
      A_STAT:  bus.cp0_r_data = status;
      A_CAUSE: bus.cp0_r_data = cause;
      A_EPC:   bus.cp0_r_data = epc_q;
      default: bus.cp0_r_data = 32'h0;
    endcase
  end

  always_comb begin
    badv_d  = badv_q;
    comp_d  = comp_q;
    epc_d   = epc_q;
    im_d    = im_q;
    exl_d   = exl_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    ipsw_d  = ipsw_q;
    exc_d   = exc_q;
    iphw_d  = bus.hw_int;
    tick_d  = ~tick_q;
    count_d = tick_q ? count_q + 32'd1 : count_q;
    ti_d    = ti_q | (count_q == comp_q);

    // Count/Compare writes are not blocked by a same-cycle exception
    if (bus.cp0_w_ena && bus.cp0_w_addr == A_COUNT) begin
      count_d = bus.cp0_w_data;
      tick_d  = 1'b0;
    end
    if (bus.cp0_w_ena && bus.cp0_w_addr == A_COMP) begin
      comp_d = bus.cp0_w_data;
      ti_d   = 1'b0;
    end

    if (bus.cp0_w_ena && !bus.exc_valid) begin
      case (bus.cp0_w_addr)
        A_STAT: begin
          im_d  = bus.cp0_w_data[15:8];
          exl_d = bus.cp0_w_data[1];
          ie_d  = bus.cp0_w_data[0];
        end
        A_CAUSE: ipsw_d = bus.cp0_w_data[9:8];
        A_EPC:   epc_d  = bus.cp0_w_data;
        default: ;
      endcase
    end

    if (bus.eret) exl_d = 1'b0;

    if (bus.exc_valid) begin
      // nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        bd_d  = bus.exc_bd;
      end
      exl_d = 1'b1;
      exc_d = bus.exc_code;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) badv_d = bus.exc_badvaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badv_q  <= '0;
      count_q <= '0;
      comp_q  <= '0;
      epc_q   <= '0;
      im_q    <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      ti_q    <= 1'b0;
      tick_q  <= 1'b0;
      iphw_q  <= '0;
      ipsw_q  <= '0;
      exc_q   <= '0;
    end else begin
      badv_q  <= badv_d;
      count_q <= count_d;
      comp_q  <= comp_d;
      epc_q   <= epc_d;
      im_q    <= im_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ti_q    <= ti_d;
      tick_q  <= tick_d;
      iphw_q  <= iphw_d;
      ipsw_q  <= ipsw_d;
      exc_q   <= exc_d;
    end
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: register masks, exceptions/eret, timer, interrupts, reset.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  cp0_regfile_if bus ();
  cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.cp0_r_addr = a;
    #1;
    chk(tag, bus.cp0_r_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_w_ena  = 1'b1;
    bus.cp0_w_addr = a;
    bus.cp0_w_data = d;
    step();
    bus.cp0_w_ena  = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                     input logic bd, input logic [31:0] bva);
    bus.exc_valid    = 1'b1;
    bus.exc_code     = code;
    bus.exc_pc       = pc;
    bus.exc_bd       = bd;
    bus.exc_badvaddr = bva;
    step();
    bus.exc_valid    = 1'b0;
  endtask

  initial begin
    bus.cp0_w_ena = 0; bus.cp0_w_addr = 0; bus.cp0_w_data = 0; bus.cp0_r_addr = 0;
    bus.hw_int = 0; bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0;
    bus.exc_bd = 0; bus.exc_badvaddr = 0; bus.eret = 0;

    #2;
    chk_rd("rst_badv", 5'd8, 32'h0);
    chk_rd("rst_count", 5'd9, 32'h0);
    chk_rd("rst_compare", 5'd11, 32'h0);
    chk_rd("rst_status", 5'd12, 32'h0040_0000);
    chk_rd("rst_cause", 5'd13, 32'h0);
    chk_rd("rst_epc", 5'd14, 32'h0);
    chk_rd("rst_unimpl", 5'd3, 32'h0);
    chk("rst_int_req", {31'b0, bus.int_req}, 32'h0);
    step();
    rst = 1'b0;

    // park Compare far away so TI stays clear
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk_rd("status_mask", 5'd12, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk_rd("cause_mask", 5'd13, 32'h0000_0300);
    chk("int_req_exl", {31'b0, bus.int_req}, 32'h0);
    mtc0(5'd8, 32'h5555_5555);
    chk_rd("badv_ro", 5'd8, 32'h0);
    mtc0(5'd12, 32'h0000_FF01);
    chk("int_req_sw", {31'b0, bus.int_req}, 32'h1);

    mtc0(5'd13, 32'h0);
    mtc0(5'd12, 32'h0);
    exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h1234_5671);
    chk_rd("exc1_epc", 5'd14, 32'hBFC0_0100);
    chk_rd("exc1_cause", 5'd13, 32'h8000_0010);
    chk_rd("exc1_badv", 5'd8, 32'h1234_5671);
    chk_rd("exc1_status", 5'd12, 32'h0040_0002);
    exc(5'd8, 32'h8000_0000, 1'b0, 32'hAAAA_0000);
    chk_rd("exc2_epc", 5'd14, 32'hBFC0_0100);
    chk_rd("exc2_cause", 5'd13, 32'h8000_0020);
    chk_rd("exc2_badv", 5'd8, 32'h1234_5671);
    bus.eret = 1'b1; step(); bus.eret = 1'b0;
    chk_rd("eret_status", 5'd12, 32'h0040_0000);

    // exception beats a same-cycle EPC write
    bus.cp0_w_ena = 1'b1; bus.cp0_w_addr = 5'd14; bus.cp0_w_data = 32'hDEAD_BEEF;
    exc(5'd0, 32'h0000_0100, 1'b0, 32'h0);
    bus.cp0_w_ena = 1'b0;
    chk_rd("exc_vs_mtc0_epc", 5'd14, 32'h0000_0100);
    chk_rd("exc_vs_mtc0_stat", 5'd12, 32'h0040_0002);
    chk_rd("exc3_cause", 5'd13, 32'h0);
    bus.eret = 1'b1;
    exc(5'd0, 32'h0000_0200, 1'b0, 32'h0);
    bus.eret = 1'b0;
    chk_rd("eret_vs_exc", 5'd12, 32'h0040_0002);
    chk_rd("eret_vs_exc_epc", 5'd14, 32'h0000_0100);
    bus.eret = 1'b1; step(); bus.eret = 1'b0;

    // timer: Compare 5, Count 0 -> TI one cycle after Count reads 5
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (10) step();
    chk_rd("timer_count5", 5'd9, 32'd5);
    chk_rd("timer_pre_ti", 5'd13, 32'h0);
    chk("timer_pre_int", {31'b0, bus.int_req}, 32'h0);
    step();
    chk_rd("timer_ti", 5'd13, 32'h4000_8000);
    chk("timer_int", {31'b0, bus.int_req}, 32'h1);
    mtc0(5'd11, 32'd20);
    chk_rd("ti_clear", 5'd13, 32'h0);
    chk("ti_clear_int", {31'b0, bus.int_req}, 32'h0);

    mtc0(5'd9, 32'hFFFF_FFFF);
    chk_rd("count_load", 5'd9, 32'hFFFF_FFFF);
    step(); step();
    chk_rd("count_wrap", 5'd9, 32'h0);

    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001;
    #1;
    chk("hw_int_lat0", {31'b0, bus.int_req}, 32'h0);
    step();
    chk_rd("hw_int_ip2", 5'd13, 32'h0000_0400);
    chk("hw_int_req", {31'b0, bus.int_req}, 32'h1);

    // arm TI, then reset asynchronously mid-cycle
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'd0);
    step();
    chk_rd("ti_arm", 5'd13, 32'h4000_8400);
    rst = 1'b1;
    #1;
    chk_rd("rst2_cause", 5'd13, 32'h0);
    chk_rd("rst2_status", 5'd12, 32'h0040_0000);
    chk_rd("rst2_count", 5'd9, 32'h0);
    chk_rd("rst2_epc", 5'd14, 32'h0);
    chk("rst2_int_req", {31'b0, bus.int_req}, 32'h0);
    bus.hw_int = 6'b0;
    step();
    rst = 1'b0;
    step();
    chk_rd("rst2_tick0", 5'd9, 32'h0);
    step();
    chk_rd("rst2_tick1", 5'd9, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file answering the execute stage's `mtc0`/`mfc0` accesses (write enable/address/data, read address → read data) and the commit-side exception/`eret` events. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It runs the Count/Compare timer and merges hardware and timer interrupts into a single interrupt request for the exception unit.

## Interface
Parameters:
- none (register map fixed: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `cp0_w_ena`  in  1  `mtc0` write strobe
- `cp0_w_addr`  in  5  write register number (`rd`)
- `cp0_w_data`  in  32  write data
- `cp0_r_addr`  in  5  read register number (`rd`)
- `cp0_r_data`  out  32  read data, combinational
- `hw_int`  in  6  external interrupt lines, level, active-high
- `exc_valid`  in  1  exception commit this cycle
- `exc_code`  in  5  ExcCode for Cause[6:2]
- `exc_pc`  in  32  PC of faulting instruction
- `exc_bd`  in  1  faulting instruction is in a delay slot
- `exc_badvaddr`  in  32  faulting address (AdEL/AdES)
- `eret`  in  1  `eret` commit this cycle
- `cp0_epc`  out  32  current EPC
- `cp0_status`  out  32  current Status
- `cp0_cause`  out  32  current Cause
- `int_req`  out  1  pending, enabled interrupt

## Operation
- Reset values: BadVAddr 0, Count 0, Compare 0, Status 0x0040_0000 (BEV=1), Cause 0, EPC 0, tick flop 0. Outputs follow: `cp0_r_data` = value at `cp0_r_addr`, `int_req` 0.
- Read: combinational mux on `cp0_r_addr`. Unimplemented addresses return 0. A read in the same cycle as a write to the same register returns the old value.
- Write masks (`cp0_w_ena`, synchronous):
  - Status: only IM[15:8], EXL[1], IE[0] are writable. BEV[22] reads 1; all other bits read 0.
  - Cause: only IP[9:8] are writable.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr and unimplemented addresses: write ignored.
- Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2]. IP[7:2] is sampled each cycle from `hw_int[5:0]`. IP[7] is `hw_int[5]` OR TI.
- Timer:
  - Tick flop toggles every cycle. Count increments when tick=1, i.e. once per 2 cycles, wrapping 0xFFFF_FFFF→0.
  - Writing Count loads `cp0_w_data` and clears tick.
  - TI sets on the edge after registered Count == Compare, and stays set until a Compare write clears it. A Compare write has priority over a same-cycle set.
- Exception (`exc_valid`=1), priority over any same-cycle `cp0_w_ena` write to Status/Cause/EPC/BadVAddr:
  - If Status.EXL=0: EPC ← `exc_bd` ? `exc_pc`−4 : `exc_pc`, and Cause.BD ← `exc_bd`.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL ← 1, ExcCode ← `exc_code`.
  - BadVAddr ← `exc_badvaddr` only when `exc_code` is 4 (AdEL) or 5 (AdES).
- `eret`: EXL ← 0. If `exc_valid` is high in the same cycle, `exc_valid` wins and `eret` is ignored.
- `int_req` = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from registered state.
- `cp0_epc`/`cp0_status`/`cp0_cause` are direct register outputs.

## Timing
- Writes, exceptions and `eret` take effect at the next rising edge and are visible on reads in the following cycle.
- Read latency 0 (same cycle).
- `hw_int` → Cause.IP → `int_req`: 1 cycle.
- Timer: first Count increment is at the 2nd edge after reset release. TI is 1 cycle after equality. `int_req` asserts in the same cycle TI is visible.
- `rst` asserted mid-operation returns all state to reset values immediately, including a pending TI and the tick phase.

## Test plan
- Reset → read regs 8/9/11/12/13/14 = 0/0/0/0x0040_0000/0/0; `int_req`=0; read addr 3 = 0.
- `mtc0` Status 0xFFFF_FFFF → read Status 0x0040_FF03. `mtc0` Cause 0xFFFF_FFFF → Cause 0x0000_0300, and with IE=1, EXL=1 `int_req`=0. Write EXL=0 → `int_req`=1 the cycle after the write.
- `exc_valid`, code 4, pc 0xBFC0_0104, bd=1, badvaddr 0x1234_5671 → EPC 0xBFC0_0100, Cause 0x8000_0010, BadVAddr 0x1234_5671, EXL=1. A second exception, code 8, pc 0x8000_0000 → EPC unchanged, ExcCode 8, BadVAddr unchanged.
- Same-cycle `exc_valid` (pc 0x100) and `mtc0` EPC 0xDEAD_BEEF → EPC 0x100. `eret` → EXL=0. `eret` together with `exc_valid` → EXL=1.
- Count=0, Compare=5, Status 0x0000_8001 → TI and `int_req` rise 1 cycle after Count reads 5 (≈11 cycles). `mtc0` Compare 20 → TI=0 next cycle.
- Count written 0xFFFF_FFFF → reads 0 two cycles later. `hw_int`=6'b000001 with IM2, IE set → Cause.IP2=1, `int_req`=1 after 1 cycle. Assert `rst` while TI=1 → all registers at reset values, `int_req`=0.
